// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one two-operand instruction at a time to a
// registered-latency ALU, owns the 8x8 register file and the flags register.
// Optional build macro ALU_SEQ_OVERLAP_EN: accept the next instruction on
// the writeback edge, forwarding the retiring result into operand reads.
module alu_op_sequencer #(
    parameter int ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr_op,
    input  logic [2:0] instr_rd,
    input  logic [2:0] instr_rs,
    input  logic [7:0] instr_imm,
    input  logic       instr_use_imm,
    output logic [7:0] alu_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_x,
    input  logic [7:0] alu_flags,
    output logic [7:0] flags,
    output logic       done,
    output logic       done_err,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, WAIT, WB} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [7:0]  rf [8];
    logic [2:0]  wb_rd;
    logic        wb_legal;
    logic        wb_wr_rf;
    logic        accept;
    logic        op_legal, op_unary, op_wr_rf;
    logic [7:0]  rd_val, rs_val, src;

    // Opcode decode and operand selection for the instruction at the port
    always_comb begin
        op_legal = ((instr_op >= 8'h01) && (instr_op <= 8'h0F)) || (instr_op == 8'h80);
        op_unary = (instr_op == 8'h0C) || (instr_op == 8'h80);
        op_wr_rf = op_legal && (instr_op != 8'h0F);
`ifdef ALU_SEQ_OVERLAP_EN
        // A read racing the retiring writeback sees the ALU result directly
        rd_val = (state == WB && wb_wr_rf && wb_rd == instr_rd) ? alu_x : rf[instr_rd];
        rs_val = (state == WB && wb_wr_rf && wb_rd == instr_rs) ? alu_x : rf[instr_rs];
`else
        rd_val = rf[instr_rd];
        rs_val = rf[instr_rs];
`endif
        src = instr_use_imm ? instr_imm : rs_val;
    end

    // Next-state and handshake decode
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        case (state)
            IDLE: instr_ready = 1'b1;
            WB: begin
`ifdef ALU_SEQ_OVERLAP_EN
                instr_ready = 1'b1;
`endif
            end
            default: ;
        endcase
        accept = instr_valid && instr_ready;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd1) state_nxt = WB;
            WB:      state_nxt = accept ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Datapath: issue on accept, count down latency, retire in WB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
            cnt      <= 4'd0;
            wb_rd    <= 3'd0;
            wb_legal <= 1'b0;
            wb_wr_rf <= 1'b0;
            alu_sel  <= 8'h00;
            alu_a    <= 8'h00;
            alu_b    <= 8'h00;
            flags    <= 8'h00;
            done     <= 1'b0;
            done_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            done_err <= 1'b0;
            if (state == WAIT) cnt <= cnt - 4'd1;
            if (state == WB) begin
                done     <= 1'b1;
                done_err <= ~wb_legal;
                alu_sel  <= 8'h00;
                if (wb_wr_rf) rf[wb_rd] <= alu_x;
                if (wb_legal) flags <= alu_flags;
            end
            // Issue comes last so a same-edge accept overrides the WB clear
            if (accept) begin
                cnt      <= 4'(ALU_LATENCY);
                wb_rd    <= instr_rd;
                wb_legal <= op_legal;
                wb_wr_rf <= op_wr_rf;
                alu_sel  <= op_legal ? instr_op : 8'h00;
                alu_a    <= op_unary ? src : rd_val;
                alu_b    <= op_unary ? 8'h00 : src;
            end
        end
    end

    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: two sequencers (latency 1 and 3), each with a behavioural
// ALU. Flags layout in the model: [6]=N, [2]=V, [1]=C(borrow on sub), [0]=Z.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       v1, v3;
    logic [7:0] op, imm;
    logic [2:0] rd, rs;
    logic       use_imm;
    logic       rdy1, rdy3, done1, done3, err1, err3;
    logic [7:0] sel1, a1, b1, x1, fl1, flags1, dbg1;
    logic [7:0] sel3, a3, b3, x3, fl3, flags3, dbg3;
    logic [2:0] da1, da3;
    int         ntests = 0;
    int         nfail  = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.ALU_LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .instr_valid(v1), .instr_ready(rdy1),
        .instr_op(op), .instr_rd(rd), .instr_rs(rs), .instr_imm(imm),
        .instr_use_imm(use_imm), .alu_sel(sel1), .alu_a(a1), .alu_b(b1),
        .alu_x(x1), .alu_flags(fl1), .flags(flags1), .done(done1),
        .done_err(err1), .dbg_addr(da1), .dbg_data(dbg1));

    alu_op_sequencer #(.ALU_LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .instr_valid(v3), .instr_ready(rdy3),
        .instr_op(op), .instr_rd(rd), .instr_rs(rs), .instr_imm(imm),
        .instr_use_imm(use_imm), .alu_sel(sel3), .alu_a(a3), .alu_b(b3),
        .alu_x(x3), .alu_flags(fl3), .flags(flags3), .done(done3),
        .done_err(err3), .dbg_addr(da3), .dbg_data(dbg3));

    // Behavioural ALU: {flags, result}
    function automatic logic [15:0] alu_f(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        w = 9'h0; c = 1'b0; v = 1'b0;
        case (s)
            8'h01: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                         v = (a[7] == b[7]) && (r[7] != a[7]); end
            8'h02, 8'h0F: begin r = a - b; c = (a < b);
                         v = (a[7] != b[7]) && (r[7] != a[7]); end
            8'h0C: r = ~a;
            8'h80: r = a;
            default: r = 8'h00;
        endcase
        return {1'b0, r[7], 3'b000, v, c, (r == 8'h00), r};
    endfunction

    logic [15:0] p1;
    logic [15:0] p3 [3];
    always @(posedge clk) begin
        p1    <= alu_f(sel1, a1, b1);
        p3[0] <= alu_f(sel3, a3, b3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign {fl1, x1} = p1;
    assign {fl3, x3} = p3[2];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction and check issue, wait, writeback and done timing
    task automatic issue(input int w, input logic [7:0] o, input logic [2:0] d,
                         input logic [2:0] s, input logic [7:0] im, input logic ui,
                         input logic [7:0] ea, input logic [7:0] eb,
                         input logic [7:0] erd, input logic [7:0] efl, input logic eerr);
        int lat;
        logic exp_wb_rdy;
        lat = (w == 3) ? 3 : 1;
`ifdef ALU_SEQ_OVERLAP_EN
        exp_wb_rdy = 1'b1;
`else
        exp_wb_rdy = 1'b0;
`endif
        @(negedge clk);
        op = o; rd = d; rs = s; imm = im; use_imm = ui;
        if (w == 3) begin v3 = 1'b1; da3 = d; end
        else        begin v1 = 1'b1; da1 = d; end
        @(posedge clk); #1;
        v1 = 1'b0; v3 = 1'b0;
        check("issue_ready", (w == 3) ? rdy3 : rdy1, 8'h00);
        check("issue_sel", (w == 3) ? sel3 : sel1, eerr ? 8'h00 : o);
        if (!eerr) begin
            check("issue_a", (w == 3) ? a3 : a1, ea);
            check("issue_b", (w == 3) ? b3 : b1, eb);
        end
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            check("wait_done", (w == 3) ? done3 : done1, 8'h00);
            check("wait_ready", (w == 3) ? rdy3 : rdy1, (k == lat) ? exp_wb_rdy : 1'b0);
        end
        @(posedge clk); #1;
        check("done", (w == 3) ? done3 : done1, 8'h01);
        check("done_err", (w == 3) ? err3 : err1, eerr);
        check("rd_val", (w == 3) ? dbg3 : dbg1, erd);
        check("flags", (w == 3) ? flags3 : flags1, efl);
        check("sel_idle", (w == 3) ? sel3 : sel1, 8'h00);
        @(posedge clk); #1;
        check("done_fall", (w == 3) ? done3 : done1, 8'h00);
        check("ready_idle", (w == 3) ? rdy3 : rdy1, 8'h01);
    endtask

    initial begin
        reset = 1'b1; v1 = 1'b0; v3 = 1'b0;
        op = 8'h00; rd = 3'd0; rs = 3'd0; imm = 8'h00; use_imm = 1'b0;
        da1 = 3'd0; da3 = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        // Reset state
        for (int i = 0; i < 8; i++) begin
            da1 = 3'(i); da3 = 3'(i); #1;
            check("rst_rf1", dbg1, 8'h00);
            check("rst_rf3", dbg3, 8'h00);
        end
        check("rst_flags", flags1, 8'h00);
        check("rst_ready", rdy1, 8'h01);
        check("rst_sel", sel1, 8'h00);
        check("rst_done", done1, 8'h00);

        // Latency 1 sequence
        issue(1, 8'h80, 3'd1, 3'd0, 8'h7F, 1'b1, 8'h7F, 8'h00, 8'h7F, 8'h00, 1'b0); // MOV r1,0x7F
        issue(1, 8'h01, 3'd1, 3'd0, 8'h01, 1'b1, 8'h7F, 8'h01, 8'h80, 8'h44, 1'b0); // ADD r1,1
        issue(1, 8'h80, 3'd2, 3'd0, 8'h05, 1'b1, 8'h05, 8'h00, 8'h05, 8'h00, 1'b0); // MOV r2,5
        issue(1, 8'h0F, 3'd2, 3'd0, 8'h05, 1'b1, 8'h05, 8'h05, 8'h05, 8'h01, 1'b0); // CMP r2,5
        issue(1, 8'h20, 3'd2, 3'd0, 8'h33, 1'b1, 8'h00, 8'h00, 8'h05, 8'h01, 1'b1); // illegal
        issue(1, 8'h80, 3'd5, 3'd0, 8'h22, 1'b1, 8'h22, 8'h00, 8'h22, 8'h00, 1'b0); // MOV r5,0x22
        issue(1, 8'h01, 3'd5, 3'd2, 8'hFF, 1'b0, 8'h22, 8'h05, 8'h27, 8'h00, 1'b0); // ADD r5,r2
        issue(1, 8'h0C, 3'd6, 3'd0, 8'h0F, 1'b1, 8'h0F, 8'h00, 8'hF0, 8'h40, 1'b0); // NOT r6,0x0F
        da1 = 3'd1; #1;
        check("r1_kept", dbg1, 8'h80);

`ifdef ALU_SEQ_OVERLAP_EN
        // Back-to-back: ADD r4,r4 accepted on MOV r4's writeback edge
        @(negedge clk);
        op = 8'h80; rd = 3'd4; rs = 3'd0; imm = 8'h03; use_imm = 1'b1; v1 = 1'b1; da1 = 3'd4;
        @(posedge clk); #1;
        op = 8'h01; rd = 3'd4; rs = 3'd4; use_imm = 1'b0;
        @(posedge clk); #1;
        check("ov_wb_ready", rdy1, 8'h01);
        @(posedge clk); #1;
        v1 = 1'b0;
        check("ov_done1", done1, 8'h01);
        check("ov_sel", sel1, 8'h01);
        check("ov_fwd_a", a1, 8'h03);
        check("ov_fwd_b", b1, 8'h03);
        repeat (2) @(posedge clk);
        #1;
        check("ov_done2", done1, 8'h01);
        check("ov_r4", dbg1, 8'h06);
`endif

        // Latency 3
        issue(3, 8'h80, 3'd3, 3'd0, 8'h10, 1'b1, 8'h10, 8'h00, 8'h10, 8'h00, 1'b0); // MOV r3,0x10
        issue(3, 8'h02, 3'd3, 3'd0, 8'h01, 1'b1, 8'h10, 8'h01, 8'h0F, 8'h00, 1'b0); // SUB r3,1

        // Reset during WAIT aborts the operation
        @(negedge clk);
        op = 8'h02; rd = 3'd3; imm = 8'h01; use_imm = 1'b1; v3 = 1'b1; da3 = 3'd3;
        @(posedge clk); #1;
        v3 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; #1;
        check("abort_rf3", dbg3, 8'h00);
        check("abort_done", done3, 8'h00);
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("abort_nodone", done3, 8'h00);
        end
        check("abort_ready", rdy3, 8'h01);
        check("abort_rf3_after", dbg3, 8'h00);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
